// File: rtl/condicionador_comandos.sv
// -----------------------------------------------------------------------------
// condicionador_comandos
//
// Input conditioner for the drone simulator. The raw joystick axes and the
// confirm button are synchronized, debounced and turned into single-cycle
// pulses, so that one physical press produces exactly one movement step.
// While a direction is held and repetir_en is set, further pulses are issued
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports:
//   clock               system clock, rising edge
//   reset               asynchronous, active-high reset
//   habilitar           0 masks every pulse and parks both axis FSMs in PARADO
//   repetir_en          1 enables hold-to-repeat on both axes
//   controle_vertical   00 none, 01 up, 10 down, 11 invalid (treated as 00)
//   controle_horizontal 00 none, 01 forward, 10 back, 11 invalid (as 00)
//   confirma            raw confirm button
//   sobe/desce          one-cycle vertical movement pulses
//   frente/tras         one-cycle horizontal movement pulses
//   confirma_pulso      one-cycle pulse on a debounced confirm press
//   db_estado           {horizontal FSM, vertical FSM}; 00 PARADO, 01 ATIVO,
//                       10 REPETINDO
// -----------------------------------------------------------------------------
module condicionador_comandos #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 300,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic       repetir_en,
    input  logic [1:0] controle_vertical,
    input  logic [1:0] controle_horizontal,
    input  logic       confirma,
    output logic       sobe,
    output logic       desce,
    output logic       frente,
    output logic       tras,
    output logic       confirma_pulso,
    output logic [3:0] db_estado
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int T_W   = $clog2(T_MAX + 1);

    localparam logic [DB_W-1:0] DB_LIMIT    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [T_W-1:0]  T_SAT       = T_W'(T_MAX);
    // The timer is cleared on the pulse edge and read before its own
    // increment, so a value of N-1 means N cycles have elapsed.
    localparam logic [T_W-1:0]  DELAY_LAST  = T_W'(REPEAT_DELAY - 1);
    localparam logic [T_W-1:0]  PERIOD_LAST = T_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        PARADO    = 2'b00,
        ATIVO     = 2'b01,
        REPETINDO = 2'b10
    } estado_t;

    // Channel 0 = vertical, 1 = horizontal, 2 = confirm (upper bit always 0)
    logic [1:0] raw_chan    [3];
    logic [1:0] deb_chan    [3];
    estado_t    estado_axis [2];
    logic       pulse_pos   [2];
    logic       pulse_neg   [2];

    always_comb begin
        raw_chan[0] = (controle_vertical   == 2'b11) ? 2'b00 : controle_vertical;
        raw_chan[1] = (controle_horizontal == 2'b11) ? 2'b00 : controle_horizontal;
        raw_chan[2] = {1'b0, confirma};
    end

    // ---------------- synchronizer + debouncer per channel -------------------
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [1:0]      sync1_reg;
            logic [1:0]      sync2_reg;
            logic [1:0]      cand_reg;   // previous synchronized sample
            logic [1:0]      deb_reg;
            logic [DB_W-1:0] cnt_reg;
            logic [DB_W-1:0] cnt_next;

            // A sample that differs from the previous one starts a new run.
            always_comb begin
                if (sync2_reg == cand_reg && cnt_reg != '0) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    cnt_next = DB_W'(1);
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 2'b00;
                    sync2_reg <= 2'b00;
                    cand_reg  <= 2'b00;
                    deb_reg   <= 2'b00;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw_chan[gi];
                    sync2_reg <= sync1_reg;
                    cand_reg  <= sync2_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_next >= DB_LIMIT) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_next;
                    end
                end
            end

            assign deb_chan[gi] = deb_reg;
        end
    endgenerate

    // ---------------- per-axis press / repeat FSM ----------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            estado_t        state_reg;
            logic [T_W-1:0] timer_reg;
            logic [1:0]     dir_reg;
            // Cleared while disabled with the axis deflected, so a direction
            // held through enable must return to 00 before it can fire.
            logic           armed_reg;
            logic           pos_reg;
            logic           neg_reg;
            logic [1:0]     d;

            assign d = deb_chan[gi];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_reg <= PARADO;
                    timer_reg <= '0;
                    dir_reg   <= 2'b00;
                    armed_reg <= 1'b1;
                    pos_reg   <= 1'b0;
                    neg_reg   <= 1'b0;
                end else begin
                    pos_reg <= 1'b0;
                    neg_reg <= 1'b0;
                    if (timer_reg != T_SAT) begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                    if (d == 2'b00) begin
                        armed_reg <= 1'b1;
                    end
                    if (!habilitar) begin
                        state_reg <= PARADO;
                        timer_reg <= '0;
                        if (d != 2'b00) begin
                            armed_reg <= 1'b0;
                        end
                    end else begin
                        // d is never 11, so d[0]/d[1] select the direction
                        case (state_reg)
                            PARADO: begin
                                if (d != 2'b00 && armed_reg) begin
                                    pos_reg   <= d[0];
                                    neg_reg   <= d[1];
                                    dir_reg   <= d;
                                    timer_reg <= '0;
                                    state_reg <= ATIVO;
                                end
                            end
                            ATIVO: begin
                                if (d == 2'b00) begin
                                    state_reg <= PARADO;
                                end else if (d != dir_reg) begin
                                    pos_reg   <= d[0];
                                    neg_reg   <= d[1];
                                    dir_reg   <= d;
                                    timer_reg <= '0;
                                end else if (repetir_en && timer_reg >= DELAY_LAST) begin
                                    pos_reg   <= dir_reg[0];
                                    neg_reg   <= dir_reg[1];
                                    timer_reg <= '0;
                                    state_reg <= REPETINDO;
                                end
                            end
                            REPETINDO: begin
                                if (d == 2'b00) begin
                                    state_reg <= PARADO;
                                end else if (d != dir_reg) begin
                                    pos_reg   <= d[0];
                                    neg_reg   <= d[1];
                                    dir_reg   <= d;
                                    timer_reg <= '0;
                                    state_reg <= ATIVO;
                                end else if (!repetir_en) begin
                                    timer_reg <= '0;
                                    state_reg <= ATIVO;
                                end else if (timer_reg >= PERIOD_LAST) begin
                                    pos_reg   <= dir_reg[0];
                                    neg_reg   <= dir_reg[1];
                                    timer_reg <= '0;
                                end
                            end
                            default: state_reg <= PARADO;
                        endcase
                    end
                end
            end

            assign estado_axis[gi] = state_reg;
            assign pulse_pos[gi]   = pos_reg;
            assign pulse_neg[gi]   = neg_reg;
        end
    endgenerate

    // ---------------- confirm edge detector ----------------------------------
    // The previous value keeps tracking while disabled, so a button held
    // through enable does not fire.
    logic conf_now;
    logic conf_prev_reg;
    logic conf_pulse_reg;

    assign conf_now = (deb_chan[2] == 2'b01);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conf_prev_reg  <= 1'b0;
            conf_pulse_reg <= 1'b0;
        end else begin
            conf_prev_reg  <= conf_now;
            conf_pulse_reg <= habilitar && conf_now && !conf_prev_reg;
        end
    end

    assign sobe           = pulse_pos[0];
    assign desce          = pulse_neg[0];
    assign frente         = pulse_pos[1];
    assign tras           = pulse_neg[1];
    assign confirma_pulso = conf_pulse_reg;
    assign db_estado      = {estado_axis[1], estado_axis[0]};

endmodule

// File: tb/tb_condicionador_comandos.sv
module tb_condicionador_comandos;
    localparam int D   = 4;
    localparam int RD  = 300;
    localparam int RP  = 100;
    localparam int LAT = D + 2;

    logic       clock = 1'b0;
    logic       reset;
    logic       habilitar;
    logic       repetir_en;
    logic [1:0] cv;
    logic [1:0] ch;
    logic       confirma;
    logic       sobe, desce, frente, tras, confirma_pulso;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    condicionador_comandos #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .habilitar          (habilitar),
        .repetir_en         (repetir_en),
        .controle_vertical  (cv),
        .controle_horizontal(ch),
        .confirma           (confirma),
        .sobe               (sobe),
        .desce              (desce),
        .frente             (frente),
        .tras               (tras),
        .confirma_pulso     (confirma_pulso),
        .db_estado          (db_estado)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // ---------------- behavioural reference model ---------------------------
    // Debounced value = v once the last D synchronized samples all equal v.
    // Axis behaviour is tracked as "held direction + time of last pulse".
    int   hist [3][D+2];   // masked raw samples, index 0 = newest
    int   deb_m [3];
    int   conf_prev_m;
    int   held_m [2];
    int   tlast_m [2];
    bit   rep_m [2];
    bit   armed_m [2];
    logic [4:0] exp_p;     // {sobe, desce, frente, tras, confirma_pulso}
    logic [3:0] exp_st;

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            deb_m[c] = 0;
            for (int i = 0; i < D + 2; i++) hist[c][i] = 0;
        end
        for (int a = 0; a < 2; a++) begin
            held_m[a] = 0; tlast_m[a] = 0; rep_m[a] = 0; armed_m[a] = 1;
        end
        conf_prev_m = 0;
        exp_p  = '0;
        exp_st = '0;
    endtask

    task automatic model_edge(input int n);
        int raw [3];
        int d, p, v;
        bit all_eq;
        raw[0] = (cv == 2'd3) ? 0 : int'(cv);
        raw[1] = (ch == 2'd3) ? 0 : int'(ch);
        raw[2] = int'(confirma);
        exp_p = '0;
        for (int a = 0; a < 2; a++) begin
            d = deb_m[a];
            p = 0;
            if (!habilitar) begin
                held_m[a] = 0; rep_m[a] = 0; armed_m[a] = (d == 0);
            end else if (d == 0) begin
                held_m[a] = 0; rep_m[a] = 0; armed_m[a] = 1;
            end else if (held_m[a] == 0) begin
                if (armed_m[a]) begin
                    p = d; held_m[a] = d; tlast_m[a] = n; rep_m[a] = 0;
                end
            end else if (d != held_m[a]) begin
                p = d; held_m[a] = d; tlast_m[a] = n; rep_m[a] = 0;
            end else if (repetir_en) begin
                if (n - tlast_m[a] >= (rep_m[a] ? RP : RD)) begin
                    p = d; tlast_m[a] = n; rep_m[a] = 1;
                end
            end else if (rep_m[a]) begin
                rep_m[a] = 0; tlast_m[a] = n;
            end
            if (a == 0) begin
                exp_p[4] = (p == 1); exp_p[3] = (p == 2);
            end else begin
                exp_p[2] = (p == 1); exp_p[1] = (p == 2);
            end
            exp_st[2*a +: 2] = (held_m[a] == 0) ? 2'b00 : (rep_m[a] ? 2'b10 : 2'b01);
        end
        exp_p[0] = habilitar && (deb_m[2] == 1) && (conf_prev_m == 0);
        conf_prev_m = deb_m[2];
        for (int c = 0; c < 3; c++) begin
            for (int i = D + 1; i > 0; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = raw[c];
            v = hist[c][2];
            all_eq = 1;
            for (int i = 2; i < D + 2; i++) if (hist[c][i] != v) all_eq = 0;
            if (all_eq && v != deb_m[c]) deb_m[c] = v;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        cyc++;
        model_edge(cyc);
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; habilitar = 1'b1; repetir_en = 1'b0;
        cv = 2'd0; ch = 2'd0; confirma = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({sobe, desce, frente, tras, confirma_pulso} !== 5'b0 || db_estado !== 4'b0) begin
            failures++;
            $display("FAIL reset_state got p=%b st=%b expected p=00000 st=0000",
                     {sobe, desce, frente, tras, confirma_pulso}, db_estado);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single_press();
        int chg, rel, n_sobe, first, rel_lat;
        bit saw_ativo;
        n_sobe = 0; first = -1; rel_lat = -1; saw_ativo = 0; rel = 0;
        habilitar = 1'b1; repetir_en = 1'b0;
        cv = 2'd1; chg = cyc + 1;
        for (int i = 0; i < 530; i++) begin
            if (i == 500) begin cv = 2'd0; rel = cyc + 1; end
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL single_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if (sobe) begin n_sobe++; first = cyc - chg; end
            if (db_estado[1:0] == 2'b01) saw_ativo = 1;
            if (i >= 500 && rel_lat < 0 && db_estado[1:0] == 2'b00) rel_lat = cyc - rel;
        end
        checks++;
        if (n_sobe != 1 || first != LAT) begin
            failures++;
            $display("FAIL single_sobe got count=%0d at=+%0d expected count=1 at=+%0d", n_sobe, first, LAT);
        end
        checks++;
        if (!saw_ativo || rel_lat != LAT) begin
            failures++;
            $display("FAIL single_state got ativo_seen=%0d release=+%0d expected 1 and +%0d",
                     saw_ativo, rel_lat, LAT);
        end
        $display("test_single_press sobe=%0d first=+%0d release=+%0d", n_sobe, first, rel_lat);
    endtask

    task automatic test_repeat();
        int chg, n;
        int t [8];
        int want [4] = '{LAT, LAT + RD, LAT + RD + RP, LAT + RD + 2 * RP};
        n = 0;
        repetir_en = 1'b1;
        ch = 2'd1; chg = cyc + 1;
        for (int i = 0; i < 580; i++) begin
            if (i == 550) ch = 2'd0;
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL repeat_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if (frente) begin
                if (n < 8) t[n] = cyc - chg;
                n++;
            end
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL repeat_count got %0d expected 4", n);
        end
        for (int k = 0; k < 4 && k < n; k++) begin
            checks++;
            if (t[k] != want[k]) begin
                failures++;
                $display("FAIL repeat_time%0d got +%0d expected +%0d", k, t[k], want[k]);
            end
        end
        repetir_en = 1'b0;
        $display("test_repeat frente_pulses=%0d", n);
    endtask

    task automatic test_bounce();
        int n_p;
        bit st_bad;
        n_p = 0; st_bad = 0;
        for (int i = 0; i < 40; i++) begin
            cv = (i < 20 && ((i / 2) % 2 == 0)) ? 2'd1 : 2'd0;
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL bounce_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if ({sobe, desce, frente, tras, confirma_pulso} != 5'b0) n_p++;
            if (db_estado != 4'b0) st_bad = 1;
        end
        checks++;
        if (n_p != 0 || st_bad) begin
            failures++;
            $display("FAIL bounce got pulses=%0d state_moved=%0d expected 0 and 0", n_p, st_bad);
        end
        $display("test_bounce pulses=%0d", n_p);
    endtask

    task automatic test_invalid_reverse();
        int c1, c2, n_other, n_f, n_t, tf, tt;
        n_other = 0; n_f = 0; n_t = 0; tf = -1; tt = -1; c1 = 0; c2 = 0;
        ch = 2'd3;
        for (int i = 0; i < 200; i++) begin
            if (i == 100) begin ch = 2'd1; c1 = cyc + 1; end
            if (i == 150) begin ch = 2'd2; c2 = cyc + 1; end
            if (i == 180) ch = 2'd0;
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL invalid_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if (frente) begin n_f++; tf = cyc - c1; end
            if (tras) begin n_t++; tt = cyc - c2; end
            if (i < 100 && {sobe, desce, frente, tras, confirma_pulso} != 5'b0) n_other++;
        end
        checks++;
        if (n_other != 0) begin
            failures++;
            $display("FAIL invalid_code got pulses=%0d expected 0", n_other);
        end
        checks++;
        if (n_f != 1 || tf != LAT || n_t != 1 || tt != LAT) begin
            failures++;
            $display("FAIL reverse got frente=%0d@+%0d tras=%0d@+%0d expected 1@+%0d 1@+%0d",
                     n_f, tf, n_t, tt, LAT, LAT);
        end
        $display("test_invalid_reverse frente=+%0d tras=+%0d", tf, tt);
    endtask

    task automatic test_enable();
        int n_held, n_d, td, n_ch, n_c, tc, chg;
        n_held = 0; n_d = 0; td = -1; n_ch = 0; n_c = 0; tc = -1; chg = 0;
        for (int i = 0; i < 250; i++) begin
            case (i)
                0:   begin habilitar = 1'b0; cv = 2'd2; end
                30:  habilitar = 1'b1;
                60:  cv = 2'd0;
                80:  begin cv = 2'd2; chg = cyc + 1; end
                100: cv = 2'd0;
                120: begin habilitar = 1'b0; confirma = 1'b1; end
                140: habilitar = 1'b1;
                160: confirma = 1'b0;
                180: begin confirma = 1'b1; chg = cyc + 1; end
                200: confirma = 1'b0;
                default: ;
            endcase
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL enable_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if (i < 80 && desce) n_held++;
            if (i >= 80 && i < 120 && desce) begin n_d++; td = cyc - chg; end
            if (i >= 120 && i < 180 && confirma_pulso) n_ch++;
            if (i >= 180 && confirma_pulso) begin n_c++; tc = cyc - chg; end
        end
        checks++;
        if (n_held != 0 || n_d != 1 || td != LAT) begin
            failures++;
            $display("FAIL enable_axis got held=%0d repress=%0d@+%0d expected 0 and 1@+%0d",
                     n_held, n_d, td, LAT);
        end
        checks++;
        if (n_ch != 0 || n_c != 1 || tc != LAT) begin
            failures++;
            $display("FAIL enable_confirm got held=%0d repress=%0d@+%0d expected 0 and 1@+%0d",
                     n_ch, n_c, tc, LAT);
        end
        $display("test_enable desce=+%0d confirma=+%0d", td, tc);
    endtask

    task automatic test_reset_mid_repeat();
        int chg, n_s, ts;
        n_s = 0; ts = -1;
        repetir_en = 1'b1; habilitar = 1'b1;
        cv = 2'd1;
        for (int i = 0; i < 320; i++) begin
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL midrep_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
        end
        checks++;
        if (db_estado[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL midrep_state got %b expected 10", db_estado[1:0]);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({sobe, desce, frente, tras, confirma_pulso} !== 5'b0 || db_estado !== 4'b0) begin
            failures++;
            $display("FAIL async_reset got p=%b st=%b expected p=00000 st=0000",
                     {sobe, desce, frente, tras, confirma_pulso}, db_estado);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        chg = cyc + 1;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) begin cv = 2'd0; repetir_en = 1'b0; end
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL postrst_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if (sobe) begin n_s++; ts = cyc - chg; end
        end
        checks++;
        if (n_s != 1 || ts != LAT) begin
            failures++;
            $display("FAIL postrst_pulse got %0d@+%0d expected 1@+%0d", n_s, ts, LAT);
        end
        $display("test_reset_mid_repeat post_reset_sobe=+%0d", ts);
    endtask

    task automatic test_random();
        int rate, n_p;
        n_p = 0;
        for (int i = 0; i < 5000; i++) begin
            rate = (i < 2000) ? 20 : 400;
            if ($urandom_range(0, rate - 1) == 0) cv = 2'($urandom_range(0, 3));
            if ($urandom_range(0, rate - 1) == 0) ch = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) confirma = ~confirma;
            if ($urandom_range(0, 299) == 0) habilitar = ~habilitar;
            if ($urandom_range(0, 199) == 0) repetir_en = ~repetir_en;
            cycle();
            checks++;
            if ({sobe, desce, frente, tras, confirma_pulso} !== exp_p || db_estado !== exp_st) begin
                failures++;
                $display("FAIL random_model cyc=%0d got p=%b st=%b expected p=%b st=%b",
                         cyc, {sobe, desce, frente, tras, confirma_pulso}, db_estado, exp_p, exp_st);
            end
            if ({sobe, desce, frente, tras, confirma_pulso} != 5'b0) n_p++;
        end
        $display("test_random cycles=5000 pulse_cycles=%0d", n_p);
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_repeat();
        test_bounce();
        test_invalid_reverse();
        test_enable();
        test_reset_mid_repeat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/condicionador_comandos.md
# condicionador_comandos

Input conditioner placed directly upstream of `simulador_drone`. Synchronizes, debounces and edge-detects the raw joystick (`controle_vertical`, `controle_horizontal`) and `confirma` inputs. Converts each press into single-cycle movement/confirm pulses, so one physical press moves the drone exactly one step. Optional hold-to-repeat generates further pulses while a direction stays held.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples needed to accept a new input value (≥1).
- `REPEAT_DELAY`, default 300: cycles from first pulse to first repeat pulse (≥2).
- `REPEAT_PERIOD`, default 100: cycles between subsequent repeat pulses (≥2).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `habilitar` in 1: 0 masks all pulses and forces axis FSMs to PARADO.
- `repetir_en` in 1: 1 enables hold-to-repeat on both axes.
- `controle_vertical` in 2: 00 none, 01 up, 10 down, 11 invalid (treated as 00).
- `controle_horizontal` in 2: 00 none, 01 forward, 10 back, 11 invalid (treated as 00).
- `confirma` in 1: raw confirm button.
- `sobe`, `desce`, `frente`, `tras` out 1: one-cycle movement pulses.
- `confirma_pulso` out 1: one-cycle confirm pulse.
- `db_estado` out 4: {horizontal FSM[1:0], vertical FSM[1:0]}. Encoding: PARADO=00, ATIVO=01, REPETINDO=10.

## Operation

- Code 11 on either axis is mapped to 00 before synchronization.
- Each of the 5 input bits passes through a 2-flop synchronizer.
- Per channel (V 2-bit, H 2-bit, confirma 1-bit), a debounce counter tracks the synchronized value. The debounced value updates only after DEBOUNCE_CYCLES consecutive identical samples that differ from the current debounced value. Any differing sample restarts the count.
- Per-axis FSM on debounced value d. V and H FSMs are identical and fully independent, so both may pulse in the same cycle.
  - PARADO: when d becomes 01 or 10, pulse the matching direction, clear the timer, go to ATIVO.
  - ATIVO: if d becomes 00, go to PARADO with no pulse. If d changes to the opposite direction, pulse the new direction, clear the timer, stay in ATIVO. If `repetir_en`=1 and the timer reaches REPEAT_DELAY, pulse, clear the timer, go to REPETINDO.
  - REPETINDO: pulse every REPEAT_PERIOD cycles. d=00 goes to PARADO. A direction change behaves as in ATIVO and goes to ATIVO. `repetir_en`=0 goes to ATIVO with the timer cleared.
- Confirm: `confirma_pulso` fires on the 0→1 transition of debounced confirma only. No repeat.
- `habilitar`=0: FSMs held in PARADO and all pulse outputs 0. Debouncers keep running.
  - When `habilitar` returns to 1 while d≠00, there is no pulse until d passes through 00 and is pressed again.
  - The same applies to confirma: its edge detector tracks while disabled, so a held button does not fire on enable.
- Timers are sized ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)) bits. They saturate and never wrap.

## Timing

- All outputs are registered.
- Reset values: all pulse outputs 0, `db_estado`=0000, synchronizers and debounced values 0, timers 0.
- Reset is asynchronous: outputs drop on assertion, not on the next edge.
- Press latency: let E0 be the first rising edge that samples the new input. The pulse is high for exactly one cycle, from edge E0+DEBOUNCE_CYCLES+2 to the following edge. With default parameters, this is 6 cycles after the change.
- The release latency to PARADO is the same.
- First repeat pulse: REPEAT_DELAY cycles after the first pulse. Later repeats are spaced REPEAT_PERIOD cycles apart.
- Reset released while an input is held: this counts as a fresh press, so a pulse appears DEBOUNCE_CYCLES+2 cycles after the first post-reset edge.
- A pulse is never wider than 1 cycle. Back-to-back pulses on one output are never closer than 2 cycles.

## Test plan

- Reset, `habilitar`=1, `repetir_en`=0, vertical 01 held 500 cycles then 00 → exactly one `sobe`, high at change+6. No other pulses. `db_estado`[1:0] goes 01 then 00.
- `repetir_en`=1, horizontal 01 held 550 cycles → `frente` pulses at change+6, +306, +406 and +506, then none after release.
- Vertical toggling 01/00 every 2 cycles for 20 cycles, then 00 → no pulses. Debounced value stays 00.
- Horizontal 11 held 100 cycles → no pulses. Then 01 for 50 cycles directly followed by 10 → `frente` at +6 after the first change, `tras` at +6 after the second.
- `habilitar`=0 with vertical 10 held, then `habilitar`=1 with it still held → no `desce`. Release 20 cycles, re-press → one `desce` at +6. Same held-through-enable check on confirma gives no `confirma_pulso` until re-pressed.
- Reset asserted mid-REPETINDO → all outputs 0 immediately, `db_estado`=0000. Reset released with input still held → a single pulse 6 cycles after the first post-reset edge.
